// File: rtl/mfp_als_spi_pkg.sv
// -----------------------------------------------------------------------------
// mfp_als_spi_pkg
// Shared definitions for the PmodALS (ADC081S021) SPI sampler:
//   - als_state_e : sampler FSM states
//   - ALS_DATA_MSB/LSB, ALS_VALUE_W : position and width of the light value
//     inside the 16-bit frame
//   - frame_has_err() : flags non-zero leading/trailing frame bits
// -----------------------------------------------------------------------------
package mfp_als_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } als_state_e;

  localparam int ALS_FRAME_W  = 16;
  localparam int ALS_DATA_MSB = 12;
  localparam int ALS_DATA_LSB = 5;
  localparam int ALS_VALUE_W  = ALS_DATA_MSB - ALS_DATA_LSB + 1;

  // The ADC sends three leading zeros and four trailing zeros around the
  // data byte; anything else there means a broken or mis-timed frame.
  // Bit 4 is not inspected.
  function automatic logic frame_has_err(input logic [ALS_FRAME_W-1:0] f);
    return (|f[ALS_FRAME_W-1:ALS_DATA_MSB+1]) | (|f[ALS_DATA_LSB-2:0]);
  endfunction

endpackage

// File: rtl/mfp_als_spi_clk_gen.sv
// -----------------------------------------------------------------------------
// mfp_als_spi_clk_gen
// SCK half-period divider for the ALS sampler (CPOL=1).
//   clk         in  system clock
//   reset       in  synchronous reset, active-high
//   enable      in  high for every cycle SCK may toggle
//   sck         out SPI clock; held high while enable is low
//   rise_strobe out one-cycle pulse in the first cycle SCK is high after a
//                   rising edge (the cycle the data bit is sampled)
// The first enabled edge drives SCK low, so SCK goes low first and each
// level then lasts CLK_DIV cycles.
// -----------------------------------------------------------------------------
module mfp_als_spi_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic rise_strobe
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= DIV_LAST;
      sck         <= 1'b1;
      rise_strobe <= 1'b0;
    end else if (!enable) begin
      // Parked at the terminal count so the first enabled edge toggles.
      div_cnt     <= DIV_LAST;
      sck         <= 1'b1;
      rise_strobe <= 1'b0;
    end else begin
      rise_strobe <= (div_cnt == DIV_LAST) && !sck;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mfp_als_spi_sampler.sv
// -----------------------------------------------------------------------------
// mfp_als_spi_sampler
// Periodic SPI master for the PmodALS ambient-light sensor. Every
// SAMPLE_PERIOD cycles it runs one FRAME_BITS-bit frame, extracts the 8-bit
// light value and flags malformed frames.
//   clk        in  system clock
//   SI_Reset   in  synchronous reset, active-high
//   spi_cs_n   out sensor chip select, active-low
//   spi_sck    out SPI clock, idles high
//   spi_sdo    in  sensor data (asynchronous, 2-flop synchronised)
//   value      out last accepted light value (frame bits 12..5)
//   valid      out one-cycle pulse when value updates
//   frame_err  out sticky malformed-frame flag, cleared by SI_Reset only
//   busy       out high while spi_cs_n is low
// Optional build macro MFP_ALS_SPI_AVG_EN: value becomes a 4-deep running
// average of the raw samples; otherwise value is the raw sample.
// -----------------------------------------------------------------------------
module mfp_als_spi_sampler
  import mfp_als_spi_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int FRAME_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   SI_Reset,
  output logic                   spi_cs_n,
  output logic                   spi_sck,
  input  logic                   spi_sdo,
  output logic [ALS_VALUE_W-1:0] value,
  output logic                   valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int         PW       = $clog2(SAMPLE_PERIOD + 1);
  localparam int         BW       = $clog2(FRAME_BITS + 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  als_state_e            state, next_state;
  logic [PW-1:0]         period_cnt;
  logic                  period_expire;
  logic [7:0]            timer;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  sdo_meta, sdo_sync;
  logic                  sck_enable, rise_strobe;
  logic [ALS_VALUE_W-1:0] sample, value_next;

  assign period_expire = (period_cnt == PW'(SAMPLE_PERIOD - 1));
  assign sample        = shreg[ALS_DATA_MSB:ALS_DATA_LSB];
  assign busy          = ~spi_cs_n;
  assign sck_enable    = (next_state == SHIFT);

  mfp_als_spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (SI_Reset),
    .enable     (sck_enable),
    .sck        (spi_sck),
    .rise_strobe(rise_strobe)
  );

  always_ff @(posedge clk) begin
    if (SI_Reset) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state is given a default before the case so no path through
  // this block leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (period_expire) next_state = CS_SETUP;
      CS_SETUP: if (timer == DIV_LAST) next_state = SHIFT;
      // The timer restarts at each rise strobe, so after the last bit it
      // runs out exactly when the final high half-period ends.
      SHIFT:    if ((bit_cnt == BW'(FRAME_BITS)) && (timer == DIV_LAST))
                  next_state = CS_HOLD;
      CS_HOLD:  if (timer == DIV_LAST) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (SI_Reset) begin
      sdo_meta   <= 1'b0;
      sdo_sync   <= 1'b0;
      period_cnt <= '0;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      spi_cs_n   <= 1'b1;
      valid      <= 1'b0;
      value      <= '0;
      frame_err  <= 1'b0;
    end else begin
      sdo_meta <= spi_sdo;
      sdo_sync <= sdo_meta;

      // Free-running in every state so the frame rate is exact.
      period_cnt <= period_expire ? '0 : period_cnt + PW'(1);

      if (next_state != state)                timer <= '0;
      else if (state == SHIFT && rise_strobe) timer <= 8'd1;
      else                                    timer <= timer + 8'd1;

      if (state == IDLE)    bit_cnt <= '0;
      else if (rise_strobe) bit_cnt <= bit_cnt + BW'(1);

      if (rise_strobe) shreg <= {shreg[FRAME_BITS-2:0], sdo_sync};

      spi_cs_n <= !(next_state inside {CS_SETUP, SHIFT, CS_HOLD});
      valid    <= (state == DONE);

      if (state == DONE) begin
        value     <= value_next;
        frame_err <= frame_err | frame_has_err(shreg);
      end
    end
  end

`ifdef MFP_ALS_SPI_AVG_EN
  logic [ALS_VALUE_W-1:0] hist0, hist1, hist2;
  logic                   hist_ok;
  logic [ALS_VALUE_W+1:0] avg_sum;

  always_comb begin
    avg_sum    = (ALS_VALUE_W+2)'(sample) + (ALS_VALUE_W+2)'(hist0)
               + (ALS_VALUE_W+2)'(hist1)  + (ALS_VALUE_W+2)'(hist2);
    value_next = hist_ok ? avg_sum[ALS_VALUE_W+1:2] : sample;
  end

  always_ff @(posedge clk) begin
    if (SI_Reset)           hist_ok <= 1'b0;
    else if (state == DONE) hist_ok <= 1'b1;
  end

  // NOTE: the history slots carry no reset; hist_ok marks them stale, and
  // the first frame after reset overwrites all of them before they are used.
  always_ff @(posedge clk) begin
    if (state == DONE) begin
      hist0 <= sample;
      hist1 <= hist_ok ? hist0 : sample;
      hist2 <= hist_ok ? hist1 : sample;
    end
  end
`else
  assign value_next = sample;
`endif

endmodule

// File: tb/tb_mfp_als_spi_sampler.sv
// -----------------------------------------------------------------------------
// tb_mfp_als_spi_sampler
// Directed bench for mfp_als_spi_sampler. Instance u_dut (CLK_DIV=2,
// SAMPLE_PERIOD=200) is driven by a sensor model that shifts a 16-bit frame
// out MSB first on SCK falling edges. Instance u_dut_slow (CLK_DIV=25,
// SAMPLE_PERIOD=50000) sees a constant-high SDO and is used for SCK timing.
// -----------------------------------------------------------------------------
module tb_mfp_als_spi_sampler;

  localparam int D    = 2;
  localparam int SP   = 200;
  localparam int LIM  = 2 * SP;
  localparam int LIM2 = 60000;

  logic       clk = 1'b0;
  logic       si_reset, sdo;
  logic       cs_n, sck, valid, frame_err, busy;
  logic [7:0] value;

  logic       rst2, sdo2;
  logic       cs_n2, sck2, valid2, frame_err2, busy2;
  logic [7:0] value2;

  always #5 clk = ~clk;

  mfp_als_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .FRAME_BITS(16)) u_dut (
    .clk(clk), .SI_Reset(si_reset), .spi_cs_n(cs_n), .spi_sck(sck),
    .spi_sdo(sdo), .value(value), .valid(valid), .frame_err(frame_err),
    .busy(busy)
  );

  mfp_als_spi_sampler #(.CLK_DIV(25), .SAMPLE_PERIOD(50000), .FRAME_BITS(16)) u_dut_slow (
    .clk(clk), .SI_Reset(rst2), .spi_cs_n(cs_n2), .spi_sck(sck2),
    .spi_sdo(sdo2), .value(value2), .valid(valid2), .frame_err(frame_err2),
    .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SCK rising edges inside frames, and SCK-low-while-deselected samples.
  logic sck_prev = 1'b1;
  int   total_rises = 0;
  int   viol = 0;
  always @(negedge clk) begin
    if (cs_n === 1'b0 && sck === 1'b1 && sck_prev === 1'b0) total_rises++;
    if (cs_n === 1'b1 && sck !== 1'b1) viol++;
    sck_prev = sck;
  end

  // Sensor model: next frame bit on every SCK falling edge while selected.
  logic [15:0] frame_word = 16'h0000;
  initial begin
    int idx;
    sdo = 1'b0;
    forever begin
      @(negedge cs_n);
      idx = 15;
      while (cs_n === 1'b0) begin
        @(negedge sck or posedge cs_n);
        if (cs_n === 1'b0 && sck === 1'b0 && idx >= 0) begin
          sdo = frame_word[idx];
          idx--;
        end
      end
    end
  end

  task automatic wait_cs_fall(input string tag, output int c);
    int n = 0;
    while (cs_n !== 1'b0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cs_timeout"}, 32'(n < LIM), 32'd1);
    c = cyc;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word,
                           input logic [7:0] exp_val, input logic exp_err,
                           output int c_cs);
    int n, r0;
    frame_word = word;
    wait_cs_fall(tag, c_cs);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    r0 = total_rises;
    n  = 0;
    while (valid !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_timeout"}, 32'(n < LIM), 32'd1);
    check({tag, "_latency"}, 32'(cyc - c_cs), 32'(34 * D + 1));
    check({tag, "_value"}, 32'(value), 32'(exp_val));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_err));
    check({tag, "_sck_rises"}, 32'(total_rises - r0), 32'd16);
    check({tag, "_cs_high"}, 32'(cs_n), 32'd1);
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
  endtask

  task automatic wait_sck2(input logic lvl, output int c);
    int n = 0;
    while (sck2 !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_sck_timeout", 32'(n < 100), 32'd1);
    c = cyc;
  endtask

  initial begin
    int r, c1, c2, c3, c4, c5, c6, c7, n, r0;
    int f1, rr, f2;
    logic [7:0] e_a, e_b, e_c, e_d;

`ifdef MFP_ALS_SPI_AVG_EN
    e_a = 8'h10; e_b = 8'h14; e_c = 8'h1C; e_d = 8'h28;
`else
    e_a = 8'h10; e_b = 8'h20; e_c = 8'h30; e_d = 8'h40;
`endif

    si_reset = 1'b1;
    rst2     = 1'b1;
    sdo2     = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd1);
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    si_reset = 1'b0;
    rst2     = 1'b0;
    r        = cyc;

    // Tests 1-3: identical data bytes keep value the same with or without averaging.
    run_frame("t1", 16'h0540, 8'h2A, 1'b0, c1);
    check("t1_first_start", 32'(c1 - r), 32'(SP));
    run_frame("t2", 16'h0540, 8'h2A, 1'b0, c2);
    check("t2_spacing", 32'(c2 - c1), 32'(SP));
    run_frame("t3_err", 16'h8540, 8'h2A, 1'b1, c3);
    check("t3_spacing", 32'(c3 - c2), 32'(SP));
    run_frame("t3_sticky", 16'h0540, 8'h2A, 1'b1, c4);
    check("t2_sck_idle_high", 32'(viol), 32'd0);

    // Test 4: reset in the middle of a frame on the 5th SCK rise.
    frame_word = 16'h0540;
    wait_cs_fall("t4", c5);
    check("t4_spacing", 32'(c5 - c4), 32'(SP));
    r0 = total_rises;
    n  = 0;
    while ((total_rises - r0) < 5 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("t4_rise_timeout", 32'(n < LIM), 32'd1);
    si_reset = 1'b1;
    @(negedge clk);
    check("t4_cs_n", 32'(cs_n), 32'd1);
    check("t4_sck", 32'(sck), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_valid", 32'(valid), 32'd0);
    check("t4_err_cleared", 32'(frame_err), 32'd0);
    check("t4_value_cleared", 32'(value), 32'd0);
    si_reset = 1'b0;
    r        = cyc;

    // Test 5: running average (or raw samples) over four frames.
    run_frame("t5_a", 16'h0200, e_a, 1'b0, c6);
    check("t4_restart", 32'(c6 - r), 32'(SP));
    run_frame("t5_b", 16'h0400, e_b, 1'b0, c7);
    run_frame("t5_c", 16'h0600, e_c, 1'b0, c7);
    run_frame("t5_d", 16'h0800, e_d, 1'b0, c7);
    check("t5_sck_idle_high", 32'(viol), 32'd0);

    // Test 6: slow instance, SCK timing and all-ones data.
    n = 0;
    while (cs_n2 !== 1'b0 && n < LIM2) begin
      @(negedge clk);
      n++;
    end
    check("t6_cs_timeout", 32'(n < LIM2), 32'd1);
    r = cyc;
    check("t6_busy", 32'(busy2), 32'd1);
    wait_sck2(1'b0, f1);
    wait_sck2(1'b1, rr);
    wait_sck2(1'b0, f2);
    check("t6_cs_setup", 32'(f1 - r), 32'd25);
    check("t6_sck_low", 32'(rr - f1), 32'd25);
    check("t6_sck_high", 32'(f2 - rr), 32'd25);
    check("t6_sck_period", 32'(f2 - f1), 32'd50);
    n = 0;
    while (valid2 !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_valid_timeout", 32'(n < 2000), 32'd1);
    check("t6_latency", 32'(cyc - r), 32'(34 * 25 + 1));
    check("t6_value", 32'(value2), 32'hFF);
    check("t6_frame_err", 32'(frame_err2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
